data_memory_arbiter: RTL and testbench

//   Shares the single-port data memory between two requesters: port 0 = CPU load/store, port 1 = debug/DMA.

---
 rtl/data_memory_arbiter_if.sv | 47 ++++
 rtl/data_memory_arbiter.sv | 162 ++++++++++++++++
 tb/tb_data_memory_arbiter.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/data_memory_arbiter_if.sv
// Requester/memory signal bundle for data_memory_arbiter.
// The master side is the two requesters plus the data memory; the slave side is the arbiter.
interface data_memory_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  REQ_0;
  logic                  WE_0;
  logic [ADDR_WIDTH-1:0] ADDR_0;
  logic [DATA_WIDTH-1:0] WDATA_0;
  logic                  GNT_0;
  logic                  DONE_0;
  logic [DATA_WIDTH-1:0] RDATA_0;
  logic                  ERR_0;

  logic                  REQ_1;
  logic                  WE_1;
  logic [ADDR_WIDTH-1:0] ADDR_1;
  logic [DATA_WIDTH-1:0] WDATA_1;
  logic                  GNT_1;
  logic                  DONE_1;
  logic [DATA_WIDTH-1:0] RDATA_1;
  logic                  ERR_1;

  logic                  MEM_WE;
  logic [ADDR_WIDTH-1:0] MEM_ADDR;
  logic [DATA_WIDTH-1:0] MEM_WDATA;
  logic [DATA_WIDTH-1:0] MEM_RDATA;

  modport master (
    output REQ_0, WE_0, ADDR_0, WDATA_0,
    output REQ_1, WE_1, ADDR_1, WDATA_1,
    output MEM_RDATA,
    input  GNT_0, DONE_0, RDATA_0, ERR_0,
    input  GNT_1, DONE_1, RDATA_1, ERR_1,
    input  MEM_WE, MEM_ADDR, MEM_WDATA
  );

  modport slave (
    input  REQ_0, WE_0, ADDR_0, WDATA_0,
    input  REQ_1, WE_1, ADDR_1, WDATA_1,
    input  MEM_RDATA,
    output GNT_0, DONE_0, RDATA_0, ERR_0,
    output GNT_1, DONE_1, RDATA_1, ERR_1,
    output MEM_WE, MEM_ADDR, MEM_WDATA
  );
endinterface

// File: rtl/data_memory_arbiter.sv
// Two-port arbiter in front of a single-port, word-addressed data memory (IDLE/ACCESS/DONE).
// Define ROUND_ROBIN_EN for alternating priority; otherwise port 0 has fixed priority.
module data_memory_arbiter #(
  parameter int unsigned MEMORY_SIZE = 64,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 32
) (
  input logic                  CLK,
  input logic                  RESET,
  data_memory_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  state_t                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  we_q, we_d;
  logic                  err_q, err_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [1:0]            gnt_q, gnt_d;
  logic [1:0]            done_q, done_d;
  logic [1:0]            err_out_q, err_out_d;

  req_t                  req_0, req_1, sel;
  logic                  any_req;
  logic                  winner;
  logic                  sel_err;
  logic                  latch;

  always_comb begin
    req_0 = '{we: bus.WE_0, addr: bus.ADDR_0, wdata: bus.WDATA_0};
    req_1 = '{we: bus.WE_1, addr: bus.ADDR_1, wdata: bus.WDATA_1};
  end

  assign any_req = bus.REQ_0 | bus.REQ_1;

`ifdef ROUND_ROBIN_EN
  logic ptr_q, ptr_d;

  // On contention the pointer decides; a lone requester always wins.
  always_comb begin
    winner = 1'b0;
    if (bus.REQ_0 && bus.REQ_1) winner = ptr_q;
    else if (bus.REQ_1)         winner = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (latch) ptr_d = ~winner;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) ptr_q <= 1'b0;
    else       ptr_q <= ptr_d;
  end
`else
  assign winner = ~bus.REQ_0 & bus.REQ_1;
`endif

  assign sel     = winner ? req_1 : req_0;
  assign sel_err = (sel.addr >= ADDR_WIDTH'(MEMORY_SIZE));

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state and next values of every registered output.
  always_comb begin
    state_d     = state_q;
    latch       = 1'b0;
    owner_d     = owner_q;
    we_d        = we_q;
    err_d       = err_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    gnt_d       = 2'b00;
    done_d      = 2'b00;
    err_out_d   = 2'b00;

    case (state_q)
      S_IDLE: begin
        if (any_req) latch = 1'b1;
      end
      S_ACCESS: begin
        state_d            = S_DONE;
        done_d[owner_q]    = 1'b1;
        err_out_d[owner_q] = err_q;
      end
      S_DONE: begin
        if (any_req) latch   = 1'b1;
        else         state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Out-of-range accesses still run the full handshake but never write.
    if (latch) begin
      state_d       = S_ACCESS;
      owner_d       = winner;
      we_d          = sel.we;
      err_d         = sel_err;
      mem_we_d      = sel.we & ~sel_err;
      mem_addr_d    = sel.addr;
      mem_wdata_d   = sel.wdata;
      gnt_d[winner] = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      owner_q     <= 1'b0;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      gnt_q       <= 2'b00;
      done_q      <= 2'b00;
      err_out_q   <= 2'b00;
    end else begin
      owner_q     <= owner_d;
      we_q        <= we_d;
      err_q       <= err_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      err_out_q   <= err_out_d;
    end
  end

  assign bus.MEM_WE    = mem_we_q;
  assign bus.MEM_ADDR  = mem_addr_q;
  assign bus.MEM_WDATA = mem_wdata_q;

  assign bus.GNT_0  = gnt_q[0];
  assign bus.GNT_1  = gnt_q[1];
  assign bus.DONE_0 = done_q[0];
  assign bus.DONE_1 = done_q[1];
  assign bus.ERR_0  = err_out_q[0];
  assign bus.ERR_1  = err_out_q[1];

  // Memory registers ReadData at the ACCESS closing edge, so read data passes through during DONE.
  assign bus.RDATA_0 = (done_q[0] && !we_q && !err_q) ? bus.MEM_RDATA : '0;
  assign bus.RDATA_1 = (done_q[1] && !we_q && !err_q) ? bus.MEM_RDATA : '0;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Self-checking bench for data_memory_arbiter: directed steps plus random traffic against a
// transaction-level memory/arbitration model. Honours ROUND_ROBIN_EN like the design.
module tb_data_memory_arbiter;

  localparam int unsigned MS = 64;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
`ifdef ROUND_ROBIN_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RESET;

  data_memory_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  data_memory_arbiter #(.MEMORY_SIZE(MS), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  logic [DW-1:0] mem     [MS];
  logic [DW-1:0] ref_mem [MS];
  int bad_we = 0;
  int vecs   = 0;
  int errs   = 0;
  bit ptr    = 1'b0;

  // Single-port memory: reads when WriteEnable=0, registers ReadData on CLK.
  always @(posedge CLK) begin
    if (bus.MEM_ADDR < AW'(MS)) begin
      if (bus.MEM_WE) mem[bus.MEM_ADDR[5:0]] <= bus.MEM_WDATA;
      else            bus.MEM_RDATA          <= mem[bus.MEM_ADDR[5:0]];
    end else begin
      if (bus.MEM_WE) bad_we <= bad_we + 1;
      bus.MEM_RDATA <= '0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input bit p, input bit r, input bit we, input logic [31:0] a, input logic [31:0] d);
    if (p) begin bus.REQ_1 = r; bus.WE_1 = we; bus.ADDR_1 = a; bus.WDATA_1 = d; end
    else   begin bus.REQ_0 = r; bus.WE_0 = we; bus.ADDR_0 = a; bus.WDATA_0 = d; end
  endtask

  task automatic set_req(input bit p, input bit r);
    if (p) bus.REQ_1 = r;
    else   bus.REQ_0 = r;
  endtask

  function automatic logic gnt(input bit p);
    return p ? bus.GNT_1 : bus.GNT_0;
  endfunction
  function automatic logic done(input bit p);
    return p ? bus.DONE_1 : bus.DONE_0;
  endfunction
  function automatic logic err(input bit p);
    return p ? bus.ERR_1 : bus.ERR_0;
  endfunction
  function automatic logic [31:0] rdata(input bit p);
    return p ? bus.RDATA_1 : bus.RDATA_0;
  endfunction

  function automatic bit oob(input logic [31:0] a);
    return a >= 32'(MS);
  endfunction

  function automatic logic [31:0] expect_rd(input bit we, input logic [31:0] a);
    if (we || oob(a)) return 32'h0;
    return ref_mem[a[5:0]];
  endfunction

  // Winner: contention goes to the pointer (round robin) or to port 0; a lone requester wins.
  function automatic bit pick(input bit r0, input bit r1);
    if (r0 && r1) return RR_EN ? ptr : 1'b0;
    return r0 ? 1'b0 : 1'b1;
  endfunction

  task automatic commit(input bit we, input logic [31:0] a, input logic [31:0] d);
    if (we && !oob(a)) ref_mem[a[5:0]] = d;
  endtask

  // Ports request together; each keeps re-requesting until n_hold grants have been issued.
  task automatic contend(input bit r0_in, input bit we0, input logic [31:0] a0, input logic [31:0] d0,
                         input bit r1_in, input bit we1, input logic [31:0] a1, input logic [31:0] d1,
                         input int n_hold);
    bit r0, r1, w, we_w;
    logic [31:0] a_w, d_w;
    int n;
    r0 = r0_in; r1 = r1_in; n = 0;
    drive(1'b0, r0, we0, a0, d0);
    drive(1'b1, r1, we1, a1, d1);
    while ((r0 || r1) && n < 16) begin
      w    = pick(r0, r1);
      we_w = w ? we1 : we0;
      a_w  = w ? a1 : a0;
      d_w  = w ? d1 : d0;
      tick;
      chk("gnt_winner", 32'(gnt(w)), 32'(1'b1));
      chk("gnt_loser", 32'(gnt(~w)), 32'(1'b0));
      chk("done_in_access", {30'b0, bus.DONE_1, bus.DONE_0}, 32'h0);
      chk("mem_we_access", 32'(bus.MEM_WE), 32'(we_w && !oob(a_w)));
      chk("mem_addr_access", bus.MEM_ADDR, a_w);
      if (we_w) chk("mem_wdata_access", bus.MEM_WDATA, d_w);
      ptr = ~w;
      if (n >= n_hold) begin
        set_req(w, 1'b0);
        if (w) r1 = 1'b0; else r0 = 1'b0;
      end
      tick;
      chk("done_owner", 32'(done(w)), 32'(1'b1));
      chk("done_other", 32'(done(~w)), 32'(1'b0));
      chk("err_owner", 32'(err(w)), 32'(oob(a_w)));
      chk("rdata_owner", rdata(w), expect_rd(we_w, a_w));
      chk("mem_we_done", 32'(bus.MEM_WE), 32'h0);
      commit(we_w, a_w, d_w);
      n++;
    end
    tick;
    chk("idle_after", {28'b0, bus.GNT_1, bus.GNT_0, bus.DONE_1, bus.DONE_0}, 32'h0);
  endtask

  task automatic single(input bit p, input bit we, input logic [31:0] a, input logic [31:0] d);
    if (p) contend(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, we, a, d, 0);
    else   contend(1'b1, we, a, d, 1'b0, 1'b0, 32'h0, 32'h0, 0);
  endtask

  initial begin
    for (int i = 0; i < int'(MS); i++) begin
      mem[i]     <= 32'(i) * 32'h0101_0101 + 32'h1;
      ref_mem[i]  = 32'(i) * 32'h0101_0101 + 32'h1;
    end
    RESET = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    tick;
    chk("reset_mem", {bus.MEM_WDATA[30:0], bus.MEM_WE} | bus.MEM_ADDR, 32'h0);
    chk("reset_hs", {26'b0, bus.GNT_1, bus.GNT_0, bus.DONE_1, bus.DONE_0, bus.ERR_1, bus.ERR_0}, 32'h0);
    chk("reset_rdata", bus.RDATA_0 | bus.RDATA_1, 32'h0);
    RESET = 1'b0;
    tick;

    // Write then read back on port 0.
    single(1'b0, 1'b1, 32'd5, 32'hDEAD_BEEF);
    single(1'b0, 1'b0, 32'd5, 32'h0);

    // Both reading with requests held; port 0 then port 1 drop after three grants.
    contend(1'b1, 1'b0, 32'd5, 32'h0, 1'b1, 1'b0, 32'd9, 32'h0, 3);

    // Back-to-back writes on port 1 with REQ held.
    drive(1'b1, 1'b1, 1'b1, 32'd0, 32'h10);
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("b2b_gnt", 32'(bus.GNT_1), 32'h1);
      chk("b2b_addr", bus.MEM_ADDR, 32'(i));
      chk("b2b_wdata", bus.MEM_WDATA, 32'h10 + 32'(i));
      chk("b2b_we", 32'(bus.MEM_WE), 32'h1);
      ptr = 1'b0;
      if (i < 3) drive(1'b1, 1'b1, 1'b1, 32'(i + 1), 32'h11 + 32'(i));
      else       set_req(1'b1, 1'b0);
      tick;
      chk("b2b_done", 32'(bus.DONE_1), 32'h1);
      chk("b2b_err", 32'(bus.ERR_1), 32'h0);
      commit(1'b1, 32'(i), 32'h10 + 32'(i));
    end
    tick;
    chk("b2b_done_clear", 32'(bus.DONE_1), 32'h0);
    for (int i = 0; i < 4; i++) single(1'b1, 1'b0, 32'(i), 32'h0);

    // Out-of-range write on port 1, then confirm address 0 untouched.
    single(1'b1, 1'b1, 32'd64, 32'hBAD0_BAD0);
    single(1'b1, 1'b0, 32'd64, 32'h0);
    single(1'b0, 1'b0, 32'd0, 32'h0);

    // Reset during ACCESS of a write to address 7.
    single(1'b0, 1'b1, 32'd7, 32'hA5A5_0007);
    drive(1'b0, 1'b1, 1'b1, 32'd7, 32'h1234_5678);
    tick;
    chk("rst_pre_we", 32'(bus.MEM_WE), 32'h1);
    #1 RESET = 1'b1;
    #1;
    chk("rst_async_mem", {bus.MEM_WDATA[30:0], bus.MEM_WE} | bus.MEM_ADDR, 32'h0);
    chk("rst_async_hs", {26'b0, bus.GNT_1, bus.GNT_0, bus.DONE_1, bus.DONE_0, bus.ERR_1, bus.ERR_0}, 32'h0);
    chk("rst_async_rdata", bus.RDATA_0 | bus.RDATA_1, 32'h0);
    set_req(1'b0, 1'b0);
    ptr = 1'b0;
    tick;
    chk("rst_no_done", 32'(bus.DONE_0), 32'h0);
    RESET = 1'b0;
    tick;
    chk("rst_no_done_after", 32'(bus.DONE_0), 32'h0);
    single(1'b0, 1'b0, 32'd7, 32'h0);

    // Idle window.
    for (int i = 0; i < 20; i++) begin
      tick;
      chk("idle", {25'b0, bus.MEM_WE, bus.GNT_1, bus.GNT_0, bus.DONE_1, bus.DONE_0, bus.ERR_1, bus.ERR_0}, 32'h0);
    end

    // Random traffic: single requests and simultaneous pairs, some out of range.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a0, a1, d0, d1;
      bit we0, we1;
      a0  = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(60, 70)) : 32'($urandom_range(0, 9));
      a1  = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(60, 70)) : 32'($urandom_range(0, 9));
      d0  = $urandom;
      d1  = $urandom;
      we0 = 1'($urandom_range(0, 1));
      we1 = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0:       single(1'b0, we0, a0, d0);
        1:       single(1'b1, we1, a1, d1);
        default: contend(1'b1, we0, a0, d0, 1'b1, we1, a1, d1, 0);
      endcase
    end

    chk("oob_write_seen", 32'(bad_we), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
